// File: rtl/foxtrot_pkg.sv
// Widths and the issue-queue entry layout shared by the renamer, the
// issue queues and the functional units.
package foxtrot_pkg;

    localparam int INST_ID_W = 6;
    localparam int PRN_W     = 6;
    localparam int MAX_OPS   = 3;

    typedef struct packed {
        logic                            valid;
        logic [INST_ID_W-1:0]            inst_id;
        logic [31:0]                     inst;
        logic [63:0]                     pc;
        logic [MAX_OPS-1:0]              op_valid;
        logic [MAX_OPS-1:0]              op_ready;
        logic [MAX_OPS-1:0][PRN_W-1:0]   op_prn;
        logic [MAX_OPS-1:0]              out_valid;
        logic [MAX_OPS-1:0][PRN_W-1:0]   out_prn;
    } iq_entry_t;

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue: remembers which slots were filled before
// which, and picks the single oldest ready slot.
module iq_age_matrix #(
    parameter int QUEUE_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [QUEUE_SIZE-1:0] alloc,
    input  logic [QUEUE_SIZE-1:0] valid,
    input  logic [QUEUE_SIZE-1:0] ready,
    output logic [QUEUE_SIZE-1:0] oldest
);

    // older[i][j] set means slot j was filled before slot i.
    logic [QUEUE_SIZE-1:0] older [QUEUE_SIZE];

    // A newly filled slot is younger than every live slot; its column is
    // cleared so stale bits from the slot's previous occupant cannot survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_SIZE; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                for (int j = 0; j < QUEUE_SIZE; j++) begin
                    if (alloc[i])      older[i][j] <= valid[j];
                    else if (alloc[j]) older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < QUEUE_SIZE; i++)
            oldest[i] = ready[i] && !(|(older[i] & ready));
    end

endmodule

// File: rtl/issue_queue_aged.sv
// Out-of-order issue queue for one FU: oldest-ready selection through an age
// matrix, multi-port wakeup CAM, PRF read in the select cycle, flush.
module issue_queue_aged
    import foxtrot_pkg::*;
#(
    parameter int INST_ID_BITS = INST_ID_W,
    parameter int PRN_BITS     = PRN_W,
    parameter int MAX_OPERANDS = MAX_OPS,
    parameter int QUEUE_SIZE   = 8,
    parameter int WAKE_PORTS   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            inst_valid,
    output logic                            queue_ready,
    input  logic [INST_ID_BITS-1:0]         inst_id,
    input  logic [31:0]                     raw_instr,
    input  logic [63:0]                     instr_pc,
    input  logic                            prn_input_valid  [MAX_OPERANDS],
    input  logic                            prn_input_ready  [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]             prn_input        [MAX_OPERANDS],
    input  logic                            prn_output_valid [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]             prn_output       [MAX_OPERANDS],
    input  logic                            wake_valid       [WAKE_PORTS],
    input  logic [PRN_BITS-1:0]             wake_prn         [WAKE_PORTS],
    output logic                            prf_read_enable  [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]             prf_read_prn     [MAX_OPERANDS],
    input  logic [63:0]                     prf_op           [MAX_OPERANDS],
    input  logic                            fu_ready,
    output logic                            issue_valid,
    output logic [INST_ID_BITS-1:0]         issue_inst_id,
    output logic [31:0]                     issue_inst,
    output logic [63:0]                     issue_op         [MAX_OPERANDS],
    output logic                            issue_out_valid  [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]             issue_out_prn    [MAX_OPERANDS],
    output logic [63:0]                     issue_pc,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] occupancy
);

    localparam int SLOT_BITS = $clog2(QUEUE_SIZE);
    localparam int OCC_BITS  = $clog2(QUEUE_SIZE+1);

    // Handshakes: an insert transfers on a cycle where inst_valid && queue_ready
    // && !flush; queue_ready comes from stored state only and never waits on
    // inst_valid. An issue transfers when fu_ready && a winner exists && !flush,
    // and issue_valid is high for exactly the following cycle.

    iq_entry_t                               entries [QUEUE_SIZE];
    iq_entry_t                               new_entry;
    iq_entry_t                               sel_entry;
    logic [QUEUE_SIZE-1:0]                   valid_vec, ready_vec, alloc_vec, sel_vec;
    logic [QUEUE_SIZE-1:0][MAX_OPERANDS-1:0] wake_hit;
    logic [SLOT_BITS-1:0]                    free_idx, sel_idx;
    logic                                    has_sel, insert_fire, issue_fire;

    always_comb begin
        for (int q = 0; q < QUEUE_SIZE; q++) begin
            valid_vec[q] = entries[q].valid;
            ready_vec[q] = entries[q].valid && &(entries[q].op_ready | ~entries[q].op_valid);
        end
    end

    assign queue_ready = ~&valid_vec;
    assign insert_fire = inst_valid && queue_ready && !flush;

    always_comb begin
        free_idx = '0;
        for (int q = QUEUE_SIZE - 1; q >= 0; q--)
            if (!valid_vec[q]) free_idx = SLOT_BITS'(q);
    end

    assign alloc_vec = insert_fire ? (QUEUE_SIZE'(1) << free_idx) : '0;

    // Wakeup CAM over stored sources; any source may match any port.
    always_comb begin
        wake_hit = '0;
        for (int q = 0; q < QUEUE_SIZE; q++)
            for (int s = 0; s < MAX_OPERANDS; s++)
                for (int w = 0; w < WAKE_PORTS; w++)
                    if (wake_valid[w] && entries[q].op_valid[s] && entries[q].op_prn[s] == wake_prn[w])
                        wake_hit[q][s] = 1'b1;
    end

    // Incoming instruction also sees broadcasts from its own insert cycle.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.inst_id = inst_id;
        new_entry.inst    = raw_instr;
        new_entry.pc      = instr_pc;
        for (int s = 0; s < MAX_OPERANDS; s++) begin
            new_entry.op_valid[s]  = prn_input_valid[s];
            new_entry.op_prn[s]    = prn_input[s];
            new_entry.op_ready[s]  = prn_input_ready[s];
            new_entry.out_valid[s] = prn_output_valid[s];
            new_entry.out_prn[s]   = prn_output[s];
            for (int w = 0; w < WAKE_PORTS; w++)
                if (wake_valid[w] && wake_prn[w] == prn_input[s]) new_entry.op_ready[s] = 1'b1;
        end
    end

    iq_age_matrix #(.QUEUE_SIZE(QUEUE_SIZE)) u_age (
        .clk    (clk),
        .rst    (rst),
        .alloc  (alloc_vec),
        .valid  (valid_vec),
        .ready  (ready_vec),
        .oldest (sel_vec)
    );

    always_comb begin
        sel_idx = '0;
        for (int q = 0; q < QUEUE_SIZE; q++)
            if (sel_vec[q]) sel_idx = SLOT_BITS'(q);
    end

    assign has_sel    = |sel_vec;
    assign sel_entry  = entries[sel_idx];
    assign issue_fire = fu_ready && has_sel && !flush;

    always_comb begin
        for (int s = 0; s < MAX_OPERANDS; s++) begin
            prf_read_enable[s] = has_sel && sel_entry.op_valid[s];
            prf_read_prn[s]    = has_sel ? sel_entry.op_prn[s] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < QUEUE_SIZE; q++) entries[q] <= '0;
        end else if (flush) begin
            for (int q = 0; q < QUEUE_SIZE; q++) entries[q].valid <= 1'b0;
        end else begin
            for (int q = 0; q < QUEUE_SIZE; q++)
                for (int s = 0; s < MAX_OPERANDS; s++)
                    if (entries[q].valid && wake_hit[q][s]) entries[q].op_ready[s] <= 1'b1;
            if (issue_fire)  entries[sel_idx].valid <= 1'b0;
            if (insert_fire) entries[free_idx] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            case ({insert_fire, issue_fire})
                2'b10:   occupancy <= occupancy + OCC_BITS'(1);
                2'b01:   occupancy <= occupancy - OCC_BITS'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid   <= 1'b0;
            issue_inst_id <= '0;
            issue_inst    <= '0;
            issue_pc      <= '0;
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                issue_op[s]        <= '0;
                issue_out_valid[s] <= 1'b0;
                issue_out_prn[s]   <= '0;
            end
        end else if (issue_fire) begin
            issue_valid   <= 1'b1;
            issue_inst_id <= sel_entry.inst_id;
            issue_inst    <= sel_entry.inst;
            issue_pc      <= sel_entry.pc;
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                issue_op[s]        <= sel_entry.op_valid[s] ? prf_op[s] : 64'd0;
                issue_out_valid[s] <= sel_entry.out_valid[s];
                issue_out_prn[s]   <= sel_entry.out_prn[s];
            end
        end else begin
            issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_issue_queue_aged.sv
// Directed bench for issue_queue_aged: issue packets are checked against an
// expected queue filled as instructions are driven.
module tb_issue_queue_aged;

    localparam int IDW  = 6;
    localparam int PW   = 6;
    localparam int NOPS = 3;
    localparam int NW   = 4;
    localparam int OCCW = 4;
    localparam int W    = IDW + 32 + 64 + NOPS*64 + NOPS + NOPS*PW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            inst_valid = 1'b0;
    logic            queue_ready;
    logic [IDW-1:0]  inst_id = '0;
    logic [31:0]     raw_instr = '0;
    logic [63:0]     instr_pc = '0;
    logic            prn_input_valid  [NOPS];
    logic            prn_input_ready  [NOPS];
    logic [PW-1:0]   prn_input        [NOPS];
    logic            prn_output_valid [NOPS];
    logic [PW-1:0]   prn_output       [NOPS];
    logic            wake_valid       [NW];
    logic [PW-1:0]   wake_prn         [NW];
    logic            prf_read_enable  [NOPS];
    logic [PW-1:0]   prf_read_prn     [NOPS];
    logic [63:0]     prf_op           [NOPS];
    logic            fu_ready = 1'b0;
    logic            issue_valid;
    logic [IDW-1:0]  issue_inst_id;
    logic [31:0]     issue_inst;
    logic [63:0]     issue_op         [NOPS];
    logic            issue_out_valid  [NOPS];
    logic [PW-1:0]   issue_out_prn    [NOPS];
    logic [63:0]     issue_pc;
    logic [OCCW-1:0] occupancy;

    int n_checks = 0;
    int n_fails  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_obs, mon_exp;

    issue_queue_aged dut (
        .clk(clk), .rst(rst), .flush(flush), .inst_valid(inst_valid), .queue_ready(queue_ready),
        .inst_id(inst_id), .raw_instr(raw_instr), .instr_pc(instr_pc),
        .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready), .prn_input(prn_input),
        .prn_output_valid(prn_output_valid), .prn_output(prn_output),
        .wake_valid(wake_valid), .wake_prn(wake_prn),
        .prf_read_enable(prf_read_enable), .prf_read_prn(prf_read_prn), .prf_op(prf_op),
        .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_inst_id(issue_inst_id),
        .issue_inst(issue_inst), .issue_op(issue_op), .issue_out_valid(issue_out_valid),
        .issue_out_prn(issue_out_prn), .issue_pc(issue_pc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] raw_of(input int id);
        return 32'hC0DE_0000 | 32'(id);
    endfunction

    function automatic logic [63:0] pc_of(input int id);
        return 64'h8000_0000 + 64'(id) * 64'd4;
    endfunction

    function automatic logic [63:0] prf_val(input int i, input logic [PW-1:0] prn);
        return 64'hF00D_0000_0000_0000 | (64'(i) << 8) | 64'(prn);
    endfunction

    // Every bench instruction uses sources 0 and 1, destination 0 = id ^ 0x20.
    function automatic logic [W-1:0] mk_exp(input int id, input int s0, input int s1);
        logic [PW-1:0] d;
        d = PW'(id) ^ 6'h20;
        return {IDW'(id), raw_of(id), pc_of(id), prf_val(0, PW'(s0)), prf_val(1, PW'(s1)), 64'd0,
                3'b100, d, 6'd0, 6'd0};
    endfunction

    // PRF model: deterministic data from the read address, poison when not read.
    always_comb begin
        for (int i = 0; i < NOPS; i++)
            prf_op[i] = prf_read_enable[i] ? prf_val(i, prf_read_prn[i]) : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    always @(negedge clk) begin
        if (!rst && issue_valid) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fails++;
                $error("FAIL issue_unexpected: observed id %0d, required no issue", issue_inst_id);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_obs = {issue_inst_id, issue_inst, issue_pc, issue_op[0], issue_op[1], issue_op[2],
                           issue_out_valid[0], issue_out_valid[1], issue_out_valid[2],
                           issue_out_prn[0], issue_out_prn[1], issue_out_prn[2]};
                n_checks++;
                assert (mon_obs === mon_exp) else begin
                    n_fails++;
                    $error("FAIL issue_packet: observed %h required %h", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input int id, input int s0, input bit r0, input int s1, input bit r1);
        inst_valid          = 1'b1;
        inst_id             = IDW'(id);
        raw_instr           = raw_of(id);
        instr_pc            = pc_of(id);
        prn_input_valid[0]  = 1'b1;  prn_input_ready[0] = r0;  prn_input[0] = PW'(s0);
        prn_input_valid[1]  = 1'b1;  prn_input_ready[1] = r1;  prn_input[1] = PW'(s1);
        prn_input_valid[2]  = 1'b0;  prn_input_ready[2] = 1'b0; prn_input[2] = '0;
        prn_output_valid[0] = 1'b1;  prn_output[0] = PW'(id) ^ 6'h20;
        prn_output_valid[1] = 1'b0;  prn_output[1] = '0;
        prn_output_valid[2] = 1'b0;  prn_output[2] = '0;
    endtask

    task automatic ins(input int id, input int s0, input bit r0, input int s1, input bit r1);
        set_inst(id, s0, r0, s1, r1);
        tick();
        inst_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NOPS; i++) begin
            prn_input_valid[i] = 1'b0; prn_input_ready[i] = 1'b0; prn_input[i] = '0;
            prn_output_valid[i] = 1'b0; prn_output[i] = '0;
        end
        for (int w = 0; w < NW; w++) begin
            wake_valid[w] = 1'b0; wake_prn[w] = '0;
        end

        // Reset state
        #12;
        chk("rst_occupancy", 64'(occupancy), 0);
        chk("rst_queue_ready", 64'(queue_ready), 1);
        chk("rst_issue_valid", 64'(issue_valid), 0);
        chk("rst_prf_enable", 64'(prf_read_enable[0]), 0);
        rst = 1'b0;
        tick();

        // Single ready instruction: issue two edges after insert
        fu_ready = 1'b1;
        exp_q.push_back(mk_exp(1, 1, 2));
        ins(1, 1, 1, 2, 1);
        chk("t1_occ_after_insert", 64'(occupancy), 1);
        chk("t1_no_issue_yet", 64'(issue_valid), 0);
        chk("t1_prf_enable0", 64'(prf_read_enable[0]), 1);
        chk("t1_prf_enable2", 64'(prf_read_enable[2]), 0);
        chk("t1_prf_prn1", 64'(prf_read_prn[1]), 2);
        tick();
        chk("t1_issue_valid", 64'(issue_valid), 1);
        chk("t1_occ_after_issue", 64'(occupancy), 0);
        tick();
        chk("t1_issue_pulse", 64'(issue_valid), 0);

        // Age order beats slot order: expect 6, 7, 5, 8
        fu_ready = 1'b0;
        ins(5, 9, 0, 3, 1);
        ins(6, 4, 1, 5, 1);
        ins(7, 6, 1, 7, 1);
        chk("t2_occ3", 64'(occupancy), 3);
        chk("t2_sel_skips_unready", 64'(prf_read_prn[0]), 4);
        exp_q.push_back(mk_exp(6, 4, 5));
        exp_q.push_back(mk_exp(7, 6, 7));
        fu_ready = 1'b1;
        tick();
        chk("t2_occ_after_issue6", 64'(occupancy), 2);
        chk("t2_queue_ready", 64'(queue_ready), 1);
        set_inst(8, 10, 1, 11, 1);
        tick();
        inst_valid = 1'b0;
        fu_ready = 1'b0;
        wake_valid[0] = 1'b1; wake_prn[0] = 6'd9;
        tick();
        wake_valid[0] = 1'b0;
        chk("t2_occ_before_wake_issue", 64'(occupancy), 2);
        chk("t2_oldest_woken_selected", 64'(prf_read_prn[0]), 9);
        exp_q.push_back(mk_exp(5, 9, 3));
        exp_q.push_back(mk_exp(8, 10, 11));
        fu_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t2_drained", 64'(occupancy), 0);

        // Wakeup in the insert cycle
        exp_q.push_back(mk_exp(3, 12, 13));
        wake_valid[2] = 1'b1; wake_prn[2] = 6'd12;
        ins(3, 12, 0, 13, 1);
        wake_valid[2] = 1'b0;
        chk("t3_ready_from_insert_wake", 64'(prf_read_enable[0]), 1);
        tick();
        chk("t3_issue_valid", 64'(issue_valid), 1);
        tick();

        // Full queue with fu_ready low; offered instruction waits
        fu_ready = 1'b0;
        for (int id = 10; id < 18; id++) begin
            exp_q.push_back(mk_exp(id, id, id + 1));
            ins(id, id, 1, id + 1, 1);
        end
        chk("t4_full_not_ready", 64'(queue_ready), 0);
        chk("t4_full_occ", 64'(occupancy), 8);
        set_inst(18, 20, 1, 21, 1);
        tick();
        chk("t4_offer_blocked", 64'(occupancy), 8);
        fu_ready = 1'b1;
        tick();
        chk("t4_occ_after_issue", 64'(occupancy), 7);
        chk("t4_ready_after_issue", 64'(queue_ready), 1);
        fu_ready = 1'b0;
        tick();
        inst_valid = 1'b0;
        chk("t4_offer_accepted", 64'(occupancy), 8);
        exp_q.push_back(mk_exp(18, 20, 21));
        fu_ready = 1'b1;
        repeat (9) tick();
        chk("t4_drained", 64'(occupancy), 0);

        // Flush beats a simultaneous insert and issue
        fu_ready = 1'b0;
        for (int id = 20; id < 24; id++) ins(id, id, 1, id + 1, 1);
        chk("t5_occ4", 64'(occupancy), 4);
        flush = 1'b1;
        fu_ready = 1'b1;
        set_inst(24, 30, 1, 31, 1);
        tick();
        flush = 1'b0;
        inst_valid = 1'b0;
        chk("t5_flush_occ", 64'(occupancy), 0);
        chk("t5_flush_issue_valid", 64'(issue_valid), 0);
        chk("t5_flush_no_sel", 64'(prf_read_enable[0]), 0);
        repeat (3) tick();
        chk("t5_still_empty", 64'(occupancy), 0);

        // Asynchronous reset between edges
        fu_ready = 1'b0;
        ins(30, 1, 1, 2, 1);
        ins(31, 3, 1, 4, 1);
        fu_ready = 1'b1;
        tick();
        fu_ready = 1'b0;
        chk("t6_pre_rst_issue_valid", 64'(issue_valid), 1);
        chk("t6_pre_rst_issue_id", 64'(issue_inst_id), 30);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_issue_valid", 64'(issue_valid), 0);
        chk("t6_rst_issue_id", 64'(issue_inst_id), 0);
        chk("t6_rst_issue_op", issue_op[0], 0);
        chk("t6_rst_occ", 64'(occupancy), 0);
        chk("t6_rst_queue_ready", 64'(queue_ready), 1);
        #3;
        rst = 1'b0;
        exp_q.push_back(mk_exp(32, 5, 6));
        ins(32, 5, 1, 6, 1);
        chk("t6_post_rst_occ", 64'(occupancy), 1);
        fu_ready = 1'b1;
        tick();
        chk("t6_post_rst_issue", 64'(issue_valid), 1);
        repeat (3) tick();
        chk("t6_empty", 64'(occupancy), 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
